sample_capture_fifo: RTL and testbench
======================================

# sample_capture_fifo

Captures the coefficient-sample words produced by the DUT sampler into a small first-word-fall-through FIFO, so the host register interface can drain them at USB pace without losing results. It sits directly downstream of the DUT's sample output (valid/ready from DUT) and upstream of the host interface's sample registers. It runs entirely in the crypto_clk domain. It provides occupancy, overflow and drop-count status for host diagnostics.

## Interface
- pOUTPUT_W, 4: coefficients per sample word
- pCOEFF_W, 23: bits per coefficient
- pADDR_W, 3: FIFO address width; depth = 2**pADDR_W (8)
- crypto_clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_clear  in  1  synchronous clear of FIFO contents and status
- i_valid  in  1  sample word present on i_samples (from DUT VALID_FROM_DUT)
- i_samples  in  pOUTPUT_W*pCOEFF_W  sample word from DUT
- o_ready  out  1  FIFO can accept a word (to DUT READY path); advisory, the DUT is not required to honour it
- i_pop  in  1  host consumed head entry; one-cycle strobe
- o_samples  out  pOUTPUT_W*pCOEFF_W  head entry (FWFT); all-zero when empty
- o_empty  out  1  count == 0
- o_full  out  1  count == 2**pADDR_W
- o_count  out  pADDR_W+1  current occupancy
- o_overflow  out  1  sticky: a word arrived while full
- o_drop_cnt  out  8  saturating count of dropped words

## Operation
- Storage: 2**pADDR_W entries; write pointer, read pointer (pADDR_W bits each, wrap naturally), occupancy counter pADDR_W+1 bits.
- Push: accepted when i_valid && !o_full (full evaluated from registered count). Entry written at wr_ptr, wr_ptr+1.
- Drop: i_valid && o_full -> word discarded. o_overflow set (sticky). o_drop_cnt+1, saturating at 255.
- Pop: effective when i_pop && !o_empty, rd_ptr+1. i_pop while empty is ignored with no state change and no error.
- Simultaneous push and pop, neither blocked: both pointers advance, count unchanged.
- Push and pop while full: pop takes effect, push is dropped (full is registered). Count becomes depth-1. Overflow and drop counter update.
- Push and pop while empty: pop ignored, push accepted, count 1.
- Count: +1 on push only, -1 on effective pop only, otherwise held.
- o_samples = mem[rd_ptr] when !o_empty, else 0. Purely from registered state; no comb path from i_pop or i_valid.
- o_ready = ~o_full. o_empty and o_full are decoded from the registered count.
- i_clear: pointers, count, o_overflow and o_drop_cnt go to 0. It has priority over a same-cycle push or pop, which are discarded. Memory contents are not cleared; they are masked by the empty gate.
- Reset (reset_n low, asynchronous): same state as clear. Outputs are o_ready=1, o_empty=1, o_full=0, o_count=0, o_overflow=0, o_drop_cnt=0, o_samples=0. Reset asserted mid-operation discards all contents immediately.

## Timing
- Push latency: word on i_samples at edge N becomes visible on o_samples after edge N if the FIFO was empty. At that point o_empty=0 and o_count=1.
- Pop: the strobe at edge N advances the head after edge N. The next entry, or 0 with o_empty=1, appears the same cycle.
- Status outputs (count, full, empty, ready, overflow, drop_cnt) update one edge after the causing event. There are no combinational input-to-output paths.
- Back-to-back pushes: one per cycle sustained until full. Back-to-back pops: one per cycle.
- reset_n deassertion is synchronised externally; the block assumes it is released clean to crypto_clk.

## Test plan
- Reset then idle: after release, o_empty=1, o_ready=1, o_count=0, o_samples=0, o_drop_cnt=0.
- Push words 1..8 on consecutive cycles, no pop: o_full=1 and o_count=8 after the 8th edge, o_ready=0. Then pop 8 times: o_samples shows 1..8 in order, ending with o_empty=1.
- Fill to 8, then push 300 more words: o_overflow=1, o_drop_cnt saturates at 255, contents still 1..8.
- Count 3, assert push (word 0xA) and pop on the same cycle: o_count stays 3, head advances, 0xA lands at the tail.
- Full FIFO, push and pop on the same cycle: o_count=7, o_drop_cnt+1. Empty FIFO, push and pop on the same cycle: o_count=1, o_samples equals the pushed word.
- With 5 entries and o_overflow=1, assert i_clear together with a push: o_count=0, o_overflow=0, o_drop_cnt=0, o_samples=0, and the pushed word is discarded. Separately, pulse reset_n low mid-fill: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sample_capture_fifo.sv
// First-word-fall-through capture FIFO for DUT sample words, with occupancy,
// sticky overflow and saturating drop-count status for the host side.
module sample_capture_fifo #(
    parameter int pOUTPUT_W = 4,
    parameter int pCOEFF_W  = 23,
    parameter int pADDR_W   = 3
) (
    input  logic                            crypto_clk,
    input  logic                            reset_n,
    input  logic                            i_clear,
    input  logic                            i_valid,
    input  logic [pOUTPUT_W*pCOEFF_W-1:0]   i_samples,
    output logic                            o_ready,
    input  logic                            i_pop,
    output logic [pOUTPUT_W*pCOEFF_W-1:0]   o_samples,
    output logic                            o_empty,
    output logic                            o_full,
    output logic [pADDR_W:0]                o_count,
    output logic                            o_overflow,
    output logic [7:0]                      o_drop_cnt
);

    localparam int WORD_W = pOUTPUT_W * pCOEFF_W;
    localparam int DEPTH  = 2 ** pADDR_W;
    localparam logic [pADDR_W:0] FULL_CNT = {1'b1, {pADDR_W{1'b0}}};

    logic [WORD_W-1:0]  mem_q [DEPTH];
    logic [pADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [pADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [pADDR_W:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic empty, full, push, pop, drop;

    // Full/empty come only from the registered count, so a same-cycle pop
    // never frees a slot for a same-cycle push.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = i_valid && !full && !i_clear;
    assign drop  = i_valid &&  full && !i_clear;
    assign pop   = i_pop   && !empty && !i_clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; stale entries are hidden by the empty gate.
    always_ff @(posedge crypto_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_samples;
    end

    assign o_samples  = empty ? '0 : mem_q[rd_ptr_q];
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_ready    = ~full;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sample_capture_fifo.sv
// Directed bench for sample_capture_fifo: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand.
module tb_sample_capture_fifo;

    localparam int W = 92;

    logic          crypto_clk = 1'b0;
    logic          reset_n;
    logic          i_clear;
    logic          i_valid;
    logic [W-1:0]  i_samples;
    logic          o_ready;
    logic          i_pop;
    logic [W-1:0]  o_samples;
    logic          o_empty;
    logic          o_full;
    logic [3:0]    o_count;
    logic          o_overflow;
    logic [7:0]    o_drop_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    sample_capture_fifo dut (
        .crypto_clk (crypto_clk),
        .reset_n    (reset_n),
        .i_clear    (i_clear),
        .i_valid    (i_valid),
        .i_samples  (i_samples),
        .o_ready    (o_ready),
        .i_pop      (i_pop),
        .o_samples  (o_samples),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 crypto_clk = ~crypto_clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        chk_cnt++;
        if (obs === exp_v) begin
            pass_cnt++;
            $display("check %-16s got %0h ok", tag, obs);
        end else begin
            $display("FAIL %-16s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        @(negedge crypto_clk);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        i_valid   = 1'b1;
        i_samples = w;
        tick();
        i_valid   = 1'b0;
    endtask

    task automatic pop_word();
        i_pop = 1'b1;
        tick();
        i_pop = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        i_clear   = 1'b0;
        i_valid   = 1'b0;
        i_samples = '0;
        i_pop     = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // reset then idle
        check("rst_empty", W'(o_empty), W'(1));
        check("rst_ready", W'(o_ready), W'(1));
        check("rst_full", W'(o_full), W'(0));
        check("rst_count", W'(o_count), W'(0));
        check("rst_samples", o_samples, W'(0));
        check("rst_drop", W'(o_drop_cnt), W'(0));
        check("rst_ovf", W'(o_overflow), W'(0));

        // fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            push_word(W'(i));
            if (i == 1) begin
                check("first_count", W'(o_count), W'(1));
                check("first_head", o_samples, W'(1));
                check("first_empty", W'(o_empty), W'(0));
            end
        end
        check("fill_full", W'(o_full), W'(1));
        check("fill_count", W'(o_count), W'(8));
        check("fill_ready", W'(o_ready), W'(0));

        // 300 pushes while full, all dropped
        i_valid   = 1'b1;
        i_samples = W'(16'hDEAD);
        tick();
        check("drop_one", W'(o_drop_cnt), W'(1));
        repeat (299) tick();
        i_valid = 1'b0;
        check("ovf_sticky", W'(o_overflow), W'(1));
        check("drop_sat", W'(o_drop_cnt), W'(255));
        check("ovf_count", W'(o_count), W'(8));

        // drain, contents intact and in order
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), o_samples, W'(i));
            pop_word();
        end
        check("drain_empty", W'(o_empty), W'(1));
        check("drain_samples", o_samples, W'(0));

        // pop while empty: no state change
        pop_word();
        check("epop_count", W'(o_count), W'(0));
        check("epop_drop", W'(o_drop_cnt), W'(255));

        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_drop", W'(o_drop_cnt), W'(0));
        check("clr_ovf", W'(o_overflow), W'(0));

        // count 3, push+pop together
        push_word(W'(8'h11));
        push_word(W'(8'h12));
        push_word(W'(8'h13));
        i_valid = 1'b1; i_samples = W'(8'h0A); i_pop = 1'b1;
        tick();
        i_valid = 1'b0; i_pop = 1'b0;
        check("pp3_count", W'(o_count), W'(3));
        check("pp3_head", o_samples, W'(8'h12));
        pop_word();
        check("pp3_h2", o_samples, W'(8'h13));
        pop_word();
        check("pp3_tail", o_samples, W'(8'h0A));
        pop_word();
        check("pp3_empty", W'(o_empty), W'(1));

        // full, push+pop together: pop wins, push dropped
        for (int i = 0; i < 8; i++) push_word(W'(8'h21 + i));
        i_valid = 1'b1; i_samples = W'(8'h99); i_pop = 1'b1;
        tick();
        i_valid = 1'b0; i_pop = 1'b0;
        check("ppf_count", W'(o_count), W'(7));
        check("ppf_drop", W'(o_drop_cnt), W'(1));
        check("ppf_ovf", W'(o_overflow), W'(1));
        for (int i = 0; i < 7; i++) begin
            check($sformatf("ppf_drain_%0d", i), o_samples, W'(8'h22 + i));
            pop_word();
        end
        check("ppf_empty", W'(o_empty), W'(1));

        // empty, push+pop together: push accepted
        i_valid = 1'b1; i_samples = W'(8'h55); i_pop = 1'b1;
        tick();
        i_valid = 1'b0; i_pop = 1'b0;
        check("ppe_count", W'(o_count), W'(1));
        check("ppe_head", o_samples, W'(8'h55));
        pop_word();

        // 5 entries with overflow set, clear wins over push
        for (int i = 0; i < 5; i++) push_word(W'(8'h31 + i));
        check("c5_count", W'(o_count), W'(5));
        check("c5_ovf", W'(o_overflow), W'(1));
        i_clear = 1'b1; i_valid = 1'b1; i_samples = W'(8'h77);
        tick();
        i_clear = 1'b0; i_valid = 1'b0;
        check("clr_count", W'(o_count), W'(0));
        check("clr_ovf2", W'(o_overflow), W'(0));
        check("clr_drop2", W'(o_drop_cnt), W'(0));
        check("clr_samples", o_samples, W'(0));
        tick();
        check("clr_discard", W'(o_count), W'(0));

        // asynchronous reset mid-fill
        push_word(W'(8'h41));
        push_word(W'(8'h42));
        i_valid = 1'b1; i_samples = W'(8'h43);
        tick();
        check("mid_count", W'(o_count), W'(3));
        reset_n = 1'b0;
        #1;
        check("arst_count", W'(o_count), W'(0));
        check("arst_empty", W'(o_empty), W'(1));
        check("arst_ready", W'(o_ready), W'(1));
        check("arst_samples", o_samples, W'(0));
        i_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_count", W'(o_count), W'(0));
        check("post_full", W'(o_full), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
